div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; data width SHALL be fixed at REG_BUS (32 bits).
REQ-002 The block SHALL have one clock and its reset SHALL be asynchronous and active-high.
REQ-003 The ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- div_start_i  in  1  request; level held by the requester until div_stop_o.
- div_cancel_i  in  1  abort the current or pending operation.
- div_op1_signed_i  in  1  dividend was negative; div_op1_i is its magnitude.
- div_op2_signed_i  in  1  divisor was negative; div_op2_i is its magnitude.
- div_op1_i  in  32  dividend magnitude (unsigned).
- div_op2_i  in  32  divisor magnitude (unsigned).
- div_stop_o  out  1  one-cycle done pulse; results valid in that cycle.
- div_res_o  out  32  signed-corrected quotient, registered.
- div_rem_o  out  32  signed-corrected remainder, registered.

Function
REQ-004 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-005 In IDLE, if div_start_i=1 and div_cancel_i=0, the block SHALL latch both magnitudes and both sign bits at the clock edge.
- If div_op2_i==0, the next state SHALL be DONE.
- Otherwise, the next state SHALL be CALC with the iteration counter cleared.
REQ-006 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first, for exactly 32 cycles.
- Each cycle: shift {partial remainder (33b), dividend} left by 1, then trial = partial remainder - divisor.
- If trial >= 0: partial remainder = trial and quotient LSB = 1; otherwise quotient LSB = 0.
REQ-007 After the 32nd CALC cycle the FSM SHALL enter DONE; div_stop_o therefore SHALL assert in the 33rd cycle after the accepting edge (1st cycle for divide-by-zero).
REQ-008 On the edge entering DONE, the block SHALL load div_res_o and div_rem_o:
- quotient = two's complement of the magnitude if op1_signed XOR op2_signed, else the magnitude;
- remainder = two's complement of the magnitude if op1_signed, else the magnitude.
REQ-009 Divide-by-zero SHALL produce div_res_o=32'hFFFFFFFF and div_rem_o = the signed-corrected dividend (magnitude negated if op1_signed).
REQ-010 Overflow (magnitudes 0x80000000/1, both signed) SHALL yield div_res_o=0x80000000 and div_rem_o=0 with no special casing.
REQ-011 div_stop_o SHALL be 1 only while in DONE; DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-012 div_res_o and div_rem_o SHALL change only on entry to DONE and SHALL hold their values at all other times.
REQ-013 div_start_i SHALL be ignored in CALC and DONE, and its deassertion during CALC SHALL NOT abort the operation.
REQ-014 Back-to-back operations SHALL have a minimum of one IDLE cycle between a div_stop_o pulse and the next accept.
REQ-015 div_cancel_i=1 in any state SHALL force IDLE at the next edge.
- div_stop_o SHALL NOT assert for the cancelled operation.
- div_res_o and div_rem_o SHALL be left unchanged.
REQ-016 If div_cancel_i and div_start_i are both 1 in IDLE, cancel SHALL win and nothing SHALL be accepted.
REQ-017 If div_cancel_i=1 in DONE, that cycle's div_stop_o SHALL still be 1 (combinational on state) and the next state SHALL be IDLE.

Reset
REQ-018 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state IDLE, counter 0, div_stop_o=0;
- div_res_o=0, div_rem_o=0;
- all internal data registers to 0.
REQ-019 Reset asserted mid-CALC SHALL abandon the operation with no div_stop_o pulse.
REQ-020 After reset release, the first clk edge SHALL be able to accept a start.

Verification
REQ-021 Unsigned: op1=100, op2=7, signs=0 -> div_stop_o high in exactly cycle 33 for one cycle, res=14, rem=2.
REQ-022 Signed: op1=7 with op1_signed=1, op2=2 -> res=0xFFFFFFFD, rem=0xFFFFFFFF.
REQ-023 Divide-by-zero: op1=5 with op1_signed=1, op2=0 -> div_stop_o in cycle 1, res=0xFFFFFFFF, rem=0xFFFFFFFB.
REQ-024 Overflow: op1=0x80000000 with op1_signed=1, op2=1 with op2_signed=1 -> res=0x80000000, rem=0.
REQ-025 Cancel: div_cancel_i pulsed in CALC cycle 10 -> no div_stop_o and outputs unchanged; a following start with 9/3 -> res=3, rem=0 in cycle 33.
REQ-026 Reset: rst asserted mid-CALC between clock edges -> div_stop_o=0 and div_res_o/div_rem_o=0 immediately; a new 100/7 after release -> res=14, rem=2.

Source files
------------

// File: rtl/div.sv
// Sequential 32-bit restoring divider on sign/magnitude operands.
// One quotient bit per cycle; results are sign-corrected and registered on entry to DONE.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start_i,
    input  logic        div_cancel_i,
    input  logic        div_op1_signed_i,
    input  logic        div_op2_signed_i,
    input  logic [31:0] div_op1_i,
    input  logic [31:0] div_op2_i,
    output logic        div_stop_o,
    output logic [31:0] div_res_o,
    output logic [31:0] div_rem_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_prem;
    logic [31:0] r_dvd;
    logic [31:0] r_dvsr;
    logic        r_s1;
    logic        r_s2;
    logic [31:0] r_res;
    logic [31:0] r_rem;

    logic        w_accept;
    logic        w_last;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_prem_nxt;
    logic [31:0] w_quo_nxt;

    assign w_accept = (r_state == IDLE) && div_start_i && !div_cancel_i;
    assign w_last   = (r_state == CALC) && (r_cnt == 5'd31);

    // r_dvd shifts the dividend out of its MSB while quotient bits fill in from the LSB.
    assign w_shift    = {r_prem, r_dvd[31]};
    assign w_trial    = w_shift - {1'b0, r_dvsr};
    assign w_ge       = !w_trial[32];
    assign w_prem_nxt = w_ge ? w_trial[31:0] : w_shift[31:0];
    assign w_quo_nxt  = {r_dvd[30:0], w_ge};

    always_comb begin
        // NOTE: default assigned first so no path through this block infers a latch.
        w_state_nxt = r_state;
        if (div_cancel_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (div_start_i) w_state_nxt = (div_op2_i == 32'd0) ? DONE : CALC;
                CALC:    if (r_cnt == 5'd31) w_state_nxt = DONE;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 5'd0;
            r_prem <= 32'd0;
            r_dvd  <= 32'd0;
            r_dvsr <= 32'd0;
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_res  <= 32'd0;
            r_rem  <= 32'd0;
        end else if (w_accept) begin
            r_cnt  <= 5'd0;
            r_prem <= 32'd0;
            r_dvd  <= div_op1_i;
            r_dvsr <= div_op2_i;
            r_s1   <= div_op1_signed_i;
            r_s2   <= div_op2_signed_i;
            // Divide-by-zero skips CALC, so its results are formed straight from the inputs.
            if (div_op2_i == 32'd0) begin
                r_res <= 32'hFFFF_FFFF;
                r_rem <= div_op1_signed_i ? (~div_op1_i + 32'd1) : div_op1_i;
            end
        end else if ((r_state == CALC) && !div_cancel_i) begin
            r_cnt  <= r_cnt + 5'd1;
            r_prem <= w_prem_nxt;
            r_dvd  <= w_quo_nxt;
            if (w_last) begin
                r_res <= (r_s1 ^ r_s2) ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
                r_rem <= r_s1 ? (~w_prem_nxt + 32'd1) : w_prem_nxt;
            end
        end
    end

    assign div_stop_o = (r_state == DONE);
    assign div_res_o  = r_res;
    assign div_rem_o  = r_rem;

endmodule
